// File: rtl/synth_spi_regs_if.sv
// SPI bus bundle between an external master and the synth_spi_regs slave.
// miso_oe lets the board tri-state miso while the slave is not selected.
interface synth_spi_regs_if;
   logic sclk;
   logic cs_n;
   logic mosi;
   logic miso;
   logic miso_oe;

   modport slave  (input sclk, cs_n, mosi, output miso, miso_oe);
   modport master (output sclk, cs_n, mosi, input miso, miso_oe);
endinterface

// File: rtl/synth_spi_regs.sv
// Oversampled mode-0 SPI slave register bank feeding synth's configuration and gate.
// Multi-byte fields go through shadows so synth never sees a half-written value.
module synth_spi_regs #(
   parameter logic [7:0] ID_VALUE = 8'hCD
) (
   input  logic            clk,
   input  logic            rst,
   synth_spi_regs_if.slave spi,
   output logic [7:0]      o_adsr_ai,
   output logic [7:0]      o_adsr_di,
   output logic [7:0]      o_adsr_s,
   output logic [7:0]      o_adsr_ri,
   output logic [31:0]     o_osc_count,
   output logic [15:0]     o_filter_a,
   output logic [15:0]     o_filter_b,
   output logic            o_trig
);
   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

   state_t      r_state, w_state_nx;
   logic [1:0]  r_sclk_s, r_csn_s, r_mosi_s;
   logic        r_sclk_d, r_csn_d;
   logic        w_sclk, w_csn, w_mosi;
   logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_byte_done;
   logic [2:0]  r_bitcnt;
   logic [6:0]  r_shift;
   logic [7:0]  w_byte, w_rd_data, r_miso_sr;
   logic        r_wr, r_miso_oe;
   logic [6:0]  r_addr, w_addr_nx, w_rd_addr;
   logic [23:0] r_osc_sh;
   logic [7:0]  r_fa_sh, r_fb_sh;

   assign w_sclk      = r_sclk_s[1];
   assign w_csn       = r_csn_s[1];
   assign w_mosi      = r_mosi_s[1];
   assign w_sclk_rise = w_sclk & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk & r_sclk_d;
   assign w_cs_fall   = r_csn_d & ~w_csn;
   assign w_byte      = {r_shift, w_mosi};
   assign w_byte_done = (r_state != S_IDLE) && !w_csn && w_sclk_rise && (r_bitcnt == 3'd7);
   assign w_addr_nx   = r_addr + 7'd1;
   assign w_rd_addr   = (r_state == S_CMD) ? w_byte[6:0] : w_addr_nx;

   assign spi.miso    = r_miso_sr[7];
   assign spi.miso_oe = r_miso_oe;

   // Cleared synchronizers make cs_n look low, so a reset inside a frame cannot
   // fabricate a falling edge; the FSM waits for a genuine new frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sclk_s <= '0;
         r_csn_s  <= '0;
         r_mosi_s <= '0;
         r_sclk_d <= 1'b0;
         r_csn_d  <= 1'b0;
      end else begin
         r_sclk_s <= {r_sclk_s[0], spi.sclk};
         r_csn_s  <= {r_csn_s[0], spi.cs_n};
         r_mosi_s <= {r_mosi_s[0], spi.mosi};
         r_sclk_d <= w_sclk;
         r_csn_d  <= w_csn;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (w_cs_fall) w_state_nx = S_CMD;
         S_CMD:   if (w_csn) w_state_nx = S_IDLE;
                  else if (w_byte_done) w_state_nx = S_DATA;
         S_DATA:  if (w_csn) w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      w_rd_data = 8'h00;
      case (w_rd_addr)
         7'h00:   w_rd_data = o_adsr_ai;
         7'h01:   w_rd_data = o_adsr_di;
         7'h02:   w_rd_data = o_adsr_s;
         7'h03:   w_rd_data = o_adsr_ri;
         7'h04:   w_rd_data = o_osc_count[7:0];
         7'h05:   w_rd_data = o_osc_count[15:8];
         7'h06:   w_rd_data = o_osc_count[23:16];
         7'h07:   w_rd_data = o_osc_count[31:24];
         7'h08:   w_rd_data = o_filter_a[7:0];
         7'h09:   w_rd_data = o_filter_a[15:8];
         7'h0A:   w_rd_data = o_filter_b[7:0];
         7'h0B:   w_rd_data = o_filter_b[15:8];
         7'h0C:   w_rd_data = {7'd0, o_trig};
         7'h0F:   w_rd_data = ID_VALUE;
         default: w_rd_data = 8'h00;
      endcase
   end

   // The falling edge right after a load (bit counter back at 0) must not shift,
   // otherwise the MSB would be gone before the master samples it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_bitcnt  <= 3'd0;
         r_shift   <= 7'd0;
         r_wr      <= 1'b0;
         r_addr    <= 7'd0;
         r_miso_sr <= 8'h00;
         r_miso_oe <= 1'b0;
      end else begin
         r_miso_oe <= (w_state_nx != S_IDLE);
         if (r_state == S_IDLE || w_csn) begin
            r_bitcnt  <= 3'd0;
            r_miso_sr <= 8'h00;
         end else begin
            if (w_sclk_rise) begin
               r_shift  <= w_byte[6:0];
               r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_byte_done) begin
               if (r_state == S_CMD) begin
                  r_wr      <= w_byte[7];
                  r_addr    <= w_byte[6:0];
                  r_miso_sr <= w_byte[7] ? 8'h00 : w_rd_data;
               end else begin
                  r_addr    <= w_addr_nx;
                  r_miso_sr <= r_wr ? 8'h00 : w_rd_data;
               end
            end else if (w_sclk_fall && r_bitcnt != 3'd0) begin
               r_miso_sr <= {r_miso_sr[6:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         o_adsr_ai   <= 8'h10;
         o_adsr_di   <= 8'h10;
         o_adsr_s    <= 8'h80;
         o_adsr_ri   <= 8'h10;
         o_osc_count <= 32'h0000_0032;
         o_filter_a  <= 16'h4000;
         o_filter_b  <= 16'h4000;
         o_trig      <= 1'b0;
         r_osc_sh    <= 24'h00_0032;
         r_fa_sh     <= 8'h00;
         r_fb_sh     <= 8'h00;
      end else if (w_byte_done && r_state == S_DATA && r_wr) begin
         case (r_addr)
            7'h00:   o_adsr_ai <= w_byte;
            7'h01:   o_adsr_di <= w_byte;
            7'h02:   o_adsr_s  <= w_byte;
            7'h03:   o_adsr_ri <= w_byte;
            7'h04:   r_osc_sh[7:0]   <= w_byte;
            7'h05:   r_osc_sh[15:8]  <= w_byte;
            7'h06:   r_osc_sh[23:16] <= w_byte;
            7'h07:   o_osc_count <= {w_byte, r_osc_sh};
            7'h08:   r_fa_sh <= w_byte;
            7'h09:   o_filter_a <= {w_byte, r_fa_sh};
            7'h0A:   r_fb_sh <= w_byte;
            7'h0B:   o_filter_b <= {w_byte, r_fb_sh};
            7'h0C:   o_trig <= w_byte[0];
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_synth_spi_regs.sv
// Bench for synth_spi_regs: directed register-map scenarios followed by random SPI
// frames, checked against a byte-level register-map model every cycle.
module tb_synth_spi_regs;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   synth_spi_regs_if spi();

   logic [7:0]  adsr_ai, adsr_di, adsr_s, adsr_ri;
   logic [31:0] osc_count;
   logic [15:0] filter_a, filter_b;
   logic        trig;

   synth_spi_regs #(.ID_VALUE(8'hCD)) dut (
      .clk         (clk),
      .rst         (rst),
      .spi         (spi),
      .o_adsr_ai   (adsr_ai),
      .o_adsr_di   (adsr_di),
      .o_adsr_s    (adsr_s),
      .o_adsr_ri   (adsr_ri),
      .o_osc_count (osc_count),
      .o_filter_a  (filter_a),
      .o_filter_b  (filter_b),
      .o_trig      (trig)
   );

   // Model: committed byte per address plus a shadow byte per address.
   logic [7:0]  m_reg [0:15];
   logic [7:0]  m_sh  [0:15];
   logic [96:0] exp_cur, exp_prev, dut_vec;
   logic [7:0]  tx_q [0:7];
   logic [7:0]  rd_q [0:7];
   int          win = 0;
   int          n_vec = 0;
   int          n_err = 0;
   bit          chk_en = 1'b0;
   bit          frame_ok = 1'b0;
   int          cs_stable = 0;
   logic        cs_prev = 1'b1;
   logic        rst_prev = 1'b0;

   assign dut_vec = {adsr_ai, adsr_di, adsr_s, adsr_ri, osc_count, filter_a, filter_b, trig};

   function automatic logic [96:0] pack_model();
      return {m_reg[0], m_reg[1], m_reg[2], m_reg[3],
              m_reg[7], m_reg[6], m_reg[5], m_reg[4],
              m_reg[9], m_reg[8], m_reg[11], m_reg[10], m_reg[12][0]};
   endfunction

   function automatic logic [7:0] model_read(input logic [6:0] a);
      return (a < 7'd16) ? m_reg[a[3:0]] : 8'h00;
   endfunction

   task automatic publish();
      exp_prev = exp_cur;
      exp_cur  = pack_model();
      win      = 4;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 16; k++) m_reg[k] = 8'h00;
      m_reg[0] = 8'h10; m_reg[1] = 8'h10; m_reg[2] = 8'h80; m_reg[3] = 8'h10;
      m_reg[4] = 8'h32; m_reg[9] = 8'h40; m_reg[11] = 8'h40; m_reg[15] = 8'hCD;
      for (int k = 0; k < 16; k++) m_sh[k] = m_reg[k];
      publish();
   endtask

   task automatic model_write(input logic [6:0] a, input logic [7:0] d);
      case (a)
         7'h00, 7'h01, 7'h02, 7'h03: m_reg[a[3:0]] = d;
         7'h04, 7'h05, 7'h06, 7'h08, 7'h0A: m_sh[a[3:0]] = d;
         7'h07: begin
            m_reg[7] = d; m_reg[6] = m_sh[6]; m_reg[5] = m_sh[5]; m_reg[4] = m_sh[4];
         end
         7'h09: begin m_reg[9] = d;  m_reg[8] = m_sh[8];   end
         7'h0B: begin m_reg[11] = d; m_reg[10] = m_sh[10]; end
         7'h0C: m_reg[12] = {7'd0, d[0]};
         default: ;
      endcase
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Outputs may sit on the previous model value for a few cycles after a
   // change (synchronizer latency), but never on anything in between.
   always @(negedge clk) begin
      if (chk_en) begin
         if (cs_prev !== spi.cs_n || rst_prev !== rst) cs_stable = 0;
         else cs_stable++;
         cs_prev  = spi.cs_n;
         rst_prev = rst;
         n_vec++;
         if (dut_vec !== exp_cur && !(win > 0 && dut_vec === exp_prev)) begin
            n_err++;
            if (n_err < 30) $display("FAIL outputs @%0t: got %h, required %h", $time, dut_vec, exp_cur);
         end
         if (win > 0) win--;
         if (cs_stable >= 4 && rst === 1'b1) begin
            n_vec++;
            if (spi.miso_oe !== (frame_ok && !spi.cs_n)) begin
               n_err++;
               if (n_err < 30) $display("FAIL miso_oe @%0t: got %b, required %b", $time, spi.miso_oe, frame_ok && !spi.cs_n);
            end
         end
      end
   end

   task automatic sclk_pulse(input logic bitv);
      spi.mosi = bitv;
      wait_clk(5);
      spi.sclk = 1'b1;
      wait_clk(5);
      spi.sclk = 1'b0;
   endtask

   // Sends cmd plus nbytes from tx_q; abort_at >= 0 raises cs_n after that many bits.
   task automatic spi_frame(input logic [7:0] cmd, input int nbytes, input int abort_at);
      int         total, bitn;
      logic [7:0] b, rx, exp_rd;
      logic [6:0] addr;
      bit         wr;
      total  = (abort_at >= 0) ? abort_at : (nbytes + 1) * 8;
      bitn   = 0;
      wr     = 1'b0;
      addr   = 7'd0;
      exp_rd = 8'h00;
      spi.cs_n = 1'b0;
      frame_ok = 1'b1;
      wait_clk(5);
      for (int by = 0; by <= nbytes && bitn < total; by++) begin
         b  = (by == 0) ? cmd : tx_q[by-1];
         rx = 8'h00;
         for (int i = 7; i >= 0 && bitn < total; i--) begin
            spi.mosi = b[i];
            wait_clk(5);
            rx[i] = spi.miso;
            spi.sclk = 1'b1;
            bitn++;
            if (i == 0) begin
               if (by == 0) begin
                  wr     = b[7];
                  addr   = b[6:0];
                  exp_rd = wr ? 8'h00 : model_read(addr);
               end else begin
                  rd_q[by-1] = rx;
                  check("miso byte", {24'd0, rx}, {24'd0, exp_rd});
                  if (wr) begin
                     model_write(addr, b);
                     publish();
                  end
                  addr   = addr + 7'd1;
                  exp_rd = wr ? 8'h00 : model_read(addr);
               end
            end
            wait_clk(5);
            spi.sclk = 1'b0;
         end
      end
      wait_clk(5);
      spi.cs_n = 1'b1;
      frame_ok = 1'b0;
      wait_clk(10);
   endtask

   initial begin
      logic [7:0] cmd;
      int         nb, ab;
      rst = 1'b0;
      spi.sclk = 1'b0;
      spi.cs_n = 1'b1;
      spi.mosi = 1'b0;
      model_reset();
      exp_prev = exp_cur;
      wait_clk(2);
      check("reset osc_count", osc_count, 32'h32);
      check("reset adsr_s", {24'd0, adsr_s}, 32'h80);
      check("reset filter_a", {16'd0, filter_a}, 32'h4000);
      check("reset trig", {31'd0, trig}, 32'd0);
      check("reset miso_oe", {31'd0, spi.miso_oe}, 32'd0);
      rst = 1'b1;
      chk_en = 1'b1;
      wait_clk(4);

      spi_frame(8'h0F, 1, -1);
      check("id read", {24'd0, rd_q[0]}, 32'hCD);
      tx_q[0] = 8'h5A;
      spi_frame(8'h80, 1, -1);
      check("adsr_ai write", {24'd0, adsr_ai}, 32'h5A);
      spi_frame(8'h00, 1, -1);
      check("adsr_ai readback", {24'd0, rd_q[0]}, 32'h5A);

      tx_q[0] = 8'h78; tx_q[1] = 8'h56; tx_q[2] = 8'h34; tx_q[3] = 8'h12;
      spi_frame(8'h84, 4, -1);
      check("osc burst", osc_count, 32'h1234_5678);

      tx_q[0] = 8'hAA;
      spi_frame(8'h88, 1, -1);
      check("filter_a shadow only", {16'd0, filter_a}, 32'h4000);
      tx_q[0] = 8'hBB;
      spi_frame(8'h89, 1, -1);
      check("filter_a commit", {16'd0, filter_a}, 32'hBBAA);

      tx_q[0] = 8'h3C;
      spi_frame(8'h81, 1, 13);
      check("abort keeps adsr_di", {24'd0, adsr_di}, 32'h10);

      // Reset in the middle of a frame, then keep clocking with cs_n still low.
      spi.cs_n = 1'b0;
      frame_ok = 1'b1;
      wait_clk(5);
      sclk_pulse(1'b1); sclk_pulse(1'b0); sclk_pulse(1'b0);
      rst = 1'b0;
      frame_ok = 1'b0;
      model_reset();
      wait_clk(2);
      rst = 1'b1;
      for (int k = 0; k < 6; k++) sclk_pulse(1'b1);
      wait_clk(5);
      spi.cs_n = 1'b1;
      wait_clk(10);
      check("mid-frame reset adsr_ai", {24'd0, adsr_ai}, 32'h10);
      check("mid-frame reset filter_a", {16'd0, filter_a}, 32'h4000);
      check("mid-frame reset osc", osc_count, 32'h32);

      tx_q[0] = 8'h77;
      spi_frame(8'h83, 1, -1);
      check("adsr_ri after reset", {24'd0, adsr_ri}, 32'h77);
      tx_q[0] = 8'h5A;
      spi_frame(8'h80, 1, -1);
      spi_frame(8'h7F, 2, -1);
      check("read 0x7F unmapped", {24'd0, rd_q[0]}, 32'h00);
      check("read wrap to 0x00", {24'd0, rd_q[1]}, 32'h5A);
      tx_q[0] = 8'h01;
      spi_frame(8'h8C, 1, -1);
      check("trig set", {31'd0, trig}, 32'd1);

      for (int f = 0; f < 40; f++) begin
         cmd[7]   = 1'($urandom_range(0, 1));
         cmd[6:0] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
         nb = $urandom_range(1, 4);
         for (int k = 0; k < 8; k++) tx_q[k] = 8'($urandom);
         ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, (nb + 1) * 8 - 1) : -1;
         spi_frame(cmd, nb, ab);
      end

      wait_clk(5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
